// File: rtl/mem_wb_stage_pkg.sv
// mem_wb_stage_pkg: widths and memory-op encodings shared by the MEM/WB stage and the mmu
package mem_wb_stage_pkg;
  localparam int XLEN = 32;
  localparam int REGIDX = 5;
  localparam logic [1:0] MEM_READ = 2'b10;
  localparam logic [1:0] MEM_WRITE = 2'b01;
  localparam int MEM_UNSIGNED_BIT = 2;
  typedef enum logic [1:0] {
    MEM_BYTE = 2'b00,
    MEM_HALF = 2'b01,
    MEM_WORD = 2'b10,
    MEM_RSVD = 2'b11
  } mem_width_e;
endpackage

// File: rtl/mem_wb_stage_if.sv
// mem_wb_stage_if: MEM-stage inputs, SRAM read word and writeback bus of the MEM/WB stage
interface mem_wb_stage_if;
  import mem_wb_stage_pkg::*;
  logic stall;
  logic flush;
  logic [4:0] mem_op_i;
  logic [XLEN-1:0] addr_i;
  logic [XLEN-1:0] alu_result_i;
  logic [REGIDX-1:0] rd_i;
  logic reg_write_i;
  logic [XLEN-1:0] dataout;
  logic [XLEN-1:0] wb_data;
  logic [REGIDX-1:0] wb_rd;
  logic wb_reg_write;
  logic load_misaligned;
  modport master (
    output stall, flush, mem_op_i, addr_i, alu_result_i, rd_i, reg_write_i, dataout,
    input wb_data, wb_rd, wb_reg_write, load_misaligned
  );
  modport slave (
    input stall, flush, mem_op_i, addr_i, alu_result_i, rd_i, reg_write_i, dataout,
    output wb_data, wb_rd, wb_reg_write, load_misaligned
  );
endinterface

// File: rtl/mem_wb_stage_load_extend.sv
// load_extend: picks the addressed byte/half/word lane, extends it and flags misalignment
module load_extend
  import mem_wb_stage_pkg::*;
(
  input  logic [XLEN-1:0] word,
  input  logic [1:0]      off,
  input  mem_width_e      width,
  input  logic            uns,
  output logic [XLEN-1:0] data,
  output logic            misaligned
);
  logic [7:0] w_byte;
  logic [15:0] w_half;
  always_comb begin
    w_byte = word[{off, 3'b000} +: 8];
    w_half = word[{off[1], 4'b0000} +: 16];
    misaligned = width == MEM_HALF ? off[0] : width == MEM_WORD ? |off : width == MEM_RSVD;
    data = misaligned ? '0
         : width == MEM_BYTE ? {{(XLEN-8){~uns & w_byte[7]}}, w_byte}
         : width == MEM_HALF ? {{(XLEN-16){~uns & w_half[15]}}, w_half}
         : word;
  end
endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM->WB pipeline register, stall hold buffer for load data and writeback mux
module mem_wb_stage
  import mem_wb_stage_pkg::*;
(
  input logic clk,
  input logic rst,
  mem_wb_stage_if.slave bus
);
  logic [4:0] r_mem_op;
  logic [1:0] r_off;
  logic [XLEN-1:0] r_alu;
  logic [REGIDX-1:0] r_rd;
  logic r_reg_write;
  logic [XLEN-1:0] r_hold_q;
  logic r_hold_v;
  logic w_load;
  logic w_store;
  logic w_mis;
  logic [XLEN-1:0] w_word;
  logic [XLEN-1:0] w_ext;
  logic w_unused;
  assign w_unused = ^bus.addr_i[XLEN-1:2];
  assign w_load = r_mem_op[4:3] == MEM_READ;
  assign w_store = |(r_mem_op[4:3] & MEM_WRITE);
  // once a stall has latched the SRAM word, later dataout changes must not disturb WB
  assign w_word = r_hold_v ? r_hold_q : bus.dataout;
  load_extend u_load_extend (
    .word       (w_word),
    .off        (r_off),
    .width      (mem_width_e'(r_mem_op[1:0])),
    .uns        (r_mem_op[MEM_UNSIGNED_BIT]),
    .data       (w_ext),
    .misaligned (w_mis)
  );
  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      r_mem_op <= '0;
      r_off <= '0;
      r_alu <= '0;
      r_rd <= '0;
      r_reg_write <= 1'b0;
      r_hold_q <= '0;
      r_hold_v <= 1'b0;
    end else if (bus.stall) begin
      if (w_load && !r_hold_v) begin
        r_hold_q <= bus.dataout;
        r_hold_v <= 1'b1;
      end
    end else begin
      r_mem_op <= bus.mem_op_i;
      r_off <= bus.addr_i[1:0];
      r_alu <= bus.alu_result_i;
      r_rd <= bus.rd_i;
      r_reg_write <= bus.reg_write_i;
      r_hold_v <= 1'b0;
    end
  end
  always_comb begin
    bus.wb_data = w_load ? w_ext : r_alu;
    bus.wb_rd = r_rd;
    bus.load_misaligned = w_load & w_mis;
    bus.wb_reg_write = r_reg_write & (r_rd != '0) & ~w_store & ~(w_load & w_mis);
  end
endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: directed self-checking bench for the MEM/WB stage
module tb_mem_wb_stage;
  import mem_wb_stage_pkg::*;
  localparam logic [4:0] OP_ADD = 5'b00000;
  localparam logic [4:0] OP_LB  = 5'b10000;
  localparam logic [4:0] OP_LBU = 5'b10100;
  localparam logic [4:0] OP_LH  = 5'b10001;
  localparam logic [4:0] OP_LHU = 5'b10101;
  localparam logic [4:0] OP_LW  = 5'b10010;
  localparam logic [4:0] OP_LWU = 5'b10110;
  localparam logic [4:0] OP_LR  = 5'b10011;
  localparam logic [4:0] OP_SW  = 5'b01010;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int errors = 0;
  mem_wb_stage_if bus();
  mem_wb_stage dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic drive(input logic [4:0] op, input logic [31:0] addr, input logic [31:0] alu,
                       input logic [4:0] rd, input logic rw);
    bus.mem_op_i = op;
    bus.addr_i = addr;
    bus.alu_result_i = alu;
    bus.rd_i = rd;
    bus.reg_write_i = rw;
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic load(input logic [4:0] op, input logic [31:0] addr, input logic [4:0] rd,
                      input logic [31:0] word);
    drive(op, addr, 32'hBAD0BAD0, rd, 1'b1);
    tick();
    bus.dataout = word;
    #1;
  endtask
  initial begin
    rst = 1'b1;
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    bus.dataout = '0;
    drive(OP_ADD, 32'h0, 32'h0, 5'd0, 1'b0);
    tick();
    tick();
    chk("reset wb_data", bus.wb_data, 32'h0);
    chk("reset wb_rd", {27'b0, bus.wb_rd}, 32'h0);
    chk("reset wb_reg_write", {31'b0, bus.wb_reg_write}, 32'h0);
    chk("reset load_misaligned", {31'b0, bus.load_misaligned}, 32'h0);
    rst = 1'b0;
    load(OP_LB, 32'h103, 5'd3, 32'h80FF1234);
    chk("LB 0x103 data", bus.wb_data, 32'hFFFFFF80);
    chk("LB 0x103 we", {31'b0, bus.wb_reg_write}, 32'h1);
    chk("LB 0x103 rd", {27'b0, bus.wb_rd}, 32'd3);
    load(OP_LBU, 32'h103, 5'd3, 32'h80FF1234);
    chk("LBU 0x103 data", bus.wb_data, 32'h00000080);
    load(OP_LB, 32'h101, 5'd3, 32'h80FF1234);
    chk("LB 0x101 data", bus.wb_data, 32'h00000012);
    load(OP_LHU, 32'h102, 5'd4, 32'h80FF1234);
    chk("LHU 0x102 data", bus.wb_data, 32'h000080FF);
    load(OP_LH, 32'h102, 5'd4, 32'h80FF1234);
    chk("LH 0x102 data", bus.wb_data, 32'hFFFF80FF);
    load(OP_LH, 32'h100, 5'd4, 32'h80FF1234);
    chk("LH 0x100 data", bus.wb_data, 32'h00001234);
    chk("LH 0x100 mis", {31'b0, bus.load_misaligned}, 32'h0);
    load(OP_LW, 32'h101, 5'd4, 32'h80FF1234);
    chk("LW 0x101 mis", {31'b0, bus.load_misaligned}, 32'h1);
    chk("LW 0x101 we", {31'b0, bus.wb_reg_write}, 32'h0);
    chk("LW 0x101 data", bus.wb_data, 32'h0);
    load(OP_LH, 32'h103, 5'd4, 32'h80FF1234);
    chk("LH 0x103 mis", {31'b0, bus.load_misaligned}, 32'h1);
    load(OP_LR, 32'h100, 5'd4, 32'h80FF1234);
    chk("reserved width mis", {31'b0, bus.load_misaligned}, 32'h1);
    load(OP_LWU, 32'h100, 5'd4, 32'h80FF1234);
    chk("LWU as LW data", bus.wb_data, 32'h80FF1234);
    load(OP_LW, 32'h100, 5'd0, 32'h80FF1234);
    chk("LW rd0 we", {31'b0, bus.wb_reg_write}, 32'h0);
    chk("LW rd0 data", bus.wb_data, 32'h80FF1234);
    drive(OP_SW, 32'h104, 32'h55, 5'd6, 1'b1);
    tick();
    chk("SW we", {31'b0, bus.wb_reg_write}, 32'h0);
    chk("SW data", bus.wb_data, 32'h55);
    load(OP_LW, 32'h100, 5'd5, 32'h11111111);
    bus.stall = 1'b1;
    drive(OP_ADD, 32'h0, 32'h99, 5'd9, 1'b1);
    chk("stall c0 data", bus.wb_data, 32'h11111111);
    tick();
    bus.dataout = 32'hDEADBEEF;
    #1;
    chk("stall c1 data", bus.wb_data, 32'h11111111);
    chk("stall c1 rd", {27'b0, bus.wb_rd}, 32'd5);
    tick();
    bus.stall = 1'b0;
    drive(OP_ADD, 32'h0, 32'h77, 5'd6, 1'b1);
    #1;
    chk("stall c2 data", bus.wb_data, 32'h11111111);
    chk("stall c2 we", {31'b0, bus.wb_reg_write}, 32'h1);
    tick();
    chk("post-stall data", bus.wb_data, 32'h77);
    chk("post-stall rd", {27'b0, bus.wb_rd}, 32'd6);
    load(OP_LW, 32'h100, 5'd7, 32'hAAAA5555);
    bus.stall = 1'b1;
    tick();
    bus.dataout = 32'h0;
    bus.flush = 1'b1;
    #1;
    chk("hold before flush", bus.wb_data, 32'hAAAA5555);
    tick();
    chk("flush we", {31'b0, bus.wb_reg_write}, 32'h0);
    chk("flush data", bus.wb_data, 32'h0);
    chk("flush rd", {27'b0, bus.wb_rd}, 32'h0);
    bus.flush = 1'b0;
    bus.stall = 1'b0;
    load(OP_LW, 32'h100, 5'd7, 32'h13572468);
    chk("hold cleared by flush", bus.wb_data, 32'h13572468);
    drive(OP_ADD, 32'h0, 32'h2A, 5'd8, 1'b1);
    tick();
    chk("ADD after flush data", bus.wb_data, 32'h2A);
    chk("ADD after flush we", {31'b0, bus.wb_reg_write}, 32'h1);
    load(OP_LW, 32'h100, 5'd9, 32'hCAFEF00D);
    chk("LW before rst", bus.wb_data, 32'hCAFEF00D);
    rst = 1'b1;
    tick();
    chk("rst pulse data", bus.wb_data, 32'h0);
    chk("rst pulse rd", {27'b0, bus.wb_rd}, 32'h0);
    chk("rst pulse we", {31'b0, bus.wb_reg_write}, 32'h0);
    chk("rst pulse mis", {31'b0, bus.load_misaligned}, 32'h0);
    rst = 1'b0;
    drive(OP_ADD, 32'h0, 32'h3C, 5'd10, 1'b1);
    tick();
    chk("ADD after rst data", bus.wb_data, 32'h3C);
    chk("ADD after rst rd", {27'b0, bus.wb_rd}, 32'd10);
    chk("ADD after rst we", {31'b0, bus.wb_reg_write}, 32'h1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
